bg_redraw_controller: RTL
=========================

Name: bg_redraw_controller

Overview:
- Sequences the 320x240, 3-bit background ROM (17-bit address, one-cycle read latency) to redraw a rectangular region of the screen into the VGA adapter, one pixel per clock.
- Shares the same ROM with a single-pixel query port. The game logic uses that port for background colour lookups, such as walkability tests.
- Sits between the game FSM (start, rectangle, query) and the ROM/VGA adapter.

Parameters:
- H_RES, 320, screen width in pixels; row stride of the ROM.
- V_RES, 240, screen height in pixels.
- ADDR_W, 17, ROM address width.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle request to redraw a rectangle
- rect_x  in  9  left column
- rect_y  in  8  top row
- rect_w  in  9  width in pixels
- rect_h  in  8  height in pixels
- busy  out  1  redraw in progress
- done  out  1  one-cycle pulse when the redraw completes
- q_req  in  1  query request
- q_x  in  9  query column
- q_y  in  8  query row
- q_valid  out  1  query result valid
- q_color  out  3  query result
- rom_addr  out  ADDR_W  address to the background ROM (the ROM registers it)
- rom_q  in  3  ROM data, valid one cycle after the address
- plot  out  1  VGA write enable
- plot_x  out  9  VGA column
- plot_y  out  8  VGA row
- plot_color  out  3  VGA colour

Behaviour:
- Reset (resetn=0 at a clock edge): state goes to IDLE. busy, done, plot, q_valid, plot_x, plot_y and the internal pointers all become 0. A reset mid-scan aborts the scan with no done pulse; plot is low from the next cycle.
- States:
  - IDLE: busy=0.
  - SCAN: issue one ROM address per non-stalled cycle.
  - DRAIN: last address issued, waiting for its data.
  - FIN: done=1 for one cycle, then IDLE.
- start is sampled only in IDLE; while busy it is ignored. In the start cycle the controller latches the rectangle and clips it:
  - if rect_x >= H_RES or rect_y >= V_RES, the region is empty;
  - effective w = min(rect_w, H_RES - rect_x);
  - effective h = min(rect_h, V_RES - rect_y).
- Empty region (w=0 or h=0 after clipping): go straight to FIN and pulse done the next cycle, with no plots.
- Address generation is incremental, with no multiplier in the loop:
  - base = rect_y*H_RES + rect_x, computed once at start;
  - the address increments by 1 per pixel;
  - at the end of a row it advances by H_RES - w + 1, x resets to rect_x and y increments.
  - Invariant: rom_addr = y*H_RES + x.
- Pipeline: for each scan address issued in cycle t, a tag (x, y, valid) is registered. In cycle t+1, plot=1, plot_x/plot_y come from the tag, and plot_color=rom_q.
  - The first plot occurs 2 cycles after the start cycle.
  - With no stalls, the last plot is at cycle 1+w*h and done is at cycle 2+w*h.
  - Pixels are emitted row-major, exactly w*h plots, no duplicates.
- Query arbitration: the query has strict priority.
  - When q_req=1, rom_addr = q_y*H_RES + q_x (a single constant multiply, off the scan path).
  - The scan pointer holds, and the next cycle has plot=0 for that slot.
  - q_valid=1 and q_color=rom_q one cycle after q_req.
  - Back-to-back queries stall the scan indefinitely; each gets its own q_valid.
  - Queries are served in every state.
  - Out-of-range query coordinates are not checked (caller responsibility).
- busy=1 from the cycle after start through the FIN cycle inclusive. A start is accepted the cycle after FIN.
- A query in the last scan cycle delays the final address; DRAIN/FIN shift accordingly.

Optional Feature:
- Macro BG_REDRAW_QUERY_EN.
- Defined: query port arbitration as described above.
- Undefined: q_req is ignored, q_valid is tied 0, q_color is tied 0, rom_addr always comes from the scan, and the scan never stalls. Port list unchanged.

Test Plan:
- Rect (10,20,3,2): rom_addr sequence 6410, 6411, 6412, 6730, 6731, 6732. Plots at cycles 2..7 with (x,y) = (10,20)..(12,21); plot_color equals the ROM model data; done at cycle 8.
- Full screen (0,0,320,240): exactly 76800 plots, the last at (319,239) with address 76799; done at cycle 76802; busy low after.
- Clipping (318,5,5,2): 4 plots, at (318,5), (319,5), (318,6), (319,6). Then (0,240,10,10): no plots, done the cycle after start.
- Query during scan: q_req at cycle 4 with (100,50) gives rom_addr 16100; q_valid at cycle 5; that slot has no plot; the scan resumes and total plots are still w*h. With the macro undefined, q_valid stays 0 and timing is unstalled.
- start pulsed while busy: ignored, and the original rectangle completes unchanged.
- resetn=0 mid-scan: plot, busy and done are 0 the next cycle with no done pulse. A subsequent start redraws correctly.

Source files
------------

// File: rtl/bg_redraw_controller.sv
// Redraws a clipped rectangle of the 320x240 background ROM into the VGA adapter, one pixel per clock.
// Optional single-pixel query port sharing the ROM is enabled by defining BG_REDRAW_QUERY_EN.
module bg_redraw_controller #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [8:0]        rect_x,
  input  logic [7:0]        rect_y,
  input  logic [8:0]        rect_w,
  input  logic [7:0]        rect_h,
  output logic              busy,
  output logic              done,
  input  logic              q_req,
  input  logic [8:0]        q_x,
  input  logic [7:0]        q_y,
  output logic              q_valid,
  output logic [2:0]        q_color,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_q,
  output logic              plot,
  output logic [8:0]        plot_x,
  output logic [7:0]        plot_y,
  output logic [2:0]        plot_color
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  function automatic logic [9:0] clip_len(input logic [9:0] len, input logic [9:0] avail);
    return (len < avail) ? len : avail;
  endfunction

  state_t            state, state_nxt;
  logic [8:0]        x0, x_end, x_cur;
  logic [7:0]        y_end, y_cur;
  logic [ADDR_W-1:0] addr_cur, row_step;
  logic              vld_p1, q_vld_p1;
  logic [8:0]        x_p1;
  logic [7:0]        y_p1;

  logic              q_take, issue, row_last, rect_last, accept, in_range, empty;
  logic [9:0]        avail_w, avail_h, w_eff, h_eff;
  logic [ADDR_W-1:0] base_addr, q_addr;

`ifdef BG_REDRAW_QUERY_EN
  assign q_take  = q_req;
  assign q_addr  = ADDR_W'(q_y) * H_RES_A + ADDR_W'(q_x);
  assign q_valid = q_vld_p1;
  assign q_color = q_vld_p1 ? rom_q : 3'd0;
`else
  logic unused_query;
  assign unused_query = ^{q_req, q_x, q_y, q_vld_p1};
  assign q_take  = 1'b0;
  assign q_addr  = '0;
  assign q_valid = 1'b0;
  assign q_color = 3'd0;
`endif

  // Clip the requested rectangle against the screen in the start cycle
  assign avail_w   = 10'(H_RES) - {1'b0, rect_x};
  assign avail_h   = 10'(V_RES) - {2'b0, rect_y};
  assign in_range  = ({1'b0, rect_x} < 10'(H_RES)) && ({2'b0, rect_y} < 10'(V_RES));
  assign w_eff     = clip_len({1'b0, rect_w}, avail_w);
  assign h_eff     = clip_len({2'b0, rect_h}, avail_h);
  assign empty     = !in_range || (w_eff == 10'd0) || (h_eff == 10'd0);
  assign base_addr = ADDR_W'(rect_y) * H_RES_A + ADDR_W'(rect_x);

  assign accept    = (state == IDLE) && start;
  assign issue     = (state == SCAN) && !q_take;
  assign row_last  = (x_cur == x_end);
  assign rect_last = row_last && (y_cur == y_end);
  assign rom_addr  = q_take ? q_addr : addr_cur;

  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign plot       = vld_p1;
  assign plot_x     = x_p1;
  assign plot_y     = y_p1;
  assign plot_color = rom_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty ? FIN : SCAN;
      SCAN:    if (issue && rect_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      vld_p1   <= 1'b0;
      q_vld_p1 <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      x_cur    <= '0;
      y_cur    <= '0;
      addr_cur <= '0;
    end else begin
      state    <= state_nxt;
      // p0 -> p1: the tag of the address issued this cycle meets its ROM data next cycle
      vld_p1   <= issue;
      q_vld_p1 <= q_take;
      if (issue) begin
        x_p1 <= x_cur;
        y_p1 <= y_cur;
      end
      if (accept) begin
        x0       <= rect_x;
        x_cur    <= rect_x;
        y_cur    <= rect_y;
        x_end    <= rect_x + w_eff[8:0] - 9'd1;
        y_end    <= rect_y + h_eff[7:0] - 8'd1;
        row_step <= H_RES_A - ADDR_W'(w_eff) + ADDR_W'(1);
        addr_cur <= base_addr;
      end else if (issue && !rect_last) begin
        if (row_last) begin
          x_cur    <= x0;
          y_cur    <= y_cur + 8'd1;
          addr_cur <= addr_cur + row_step;
        end else begin
          x_cur    <= x_cur + 9'd1;
          addr_cur <= addr_cur + ADDR_W'(1);
        end
      end
    end
  end

endmodule
